// File: rtl/mips_data_port_master.sv
// ============================================================================
// Module      : mips_data_port_master
// Description : Single-outstanding MIPS load/store initiator for the data port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_data_port_master #(
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_result,
    output logic [31:0] dp_address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read_dp,
    output logic        write_dp,
    input  logic [31:0] dp_readdata,
    input  logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    logic w_unused_ok;
    assign w_unused_ok = (RESET_PC_UNUSED == 0);

    state_t     r_state;
    logic       r_is_store;
    logic       r_signed;
    logic [1:0] r_size;
    logic [1:0] r_off;

    logic        w_valid;
    logic        w_is_store;
    logic        w_signed;
    logic [1:0]  w_size;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Decode of the incoming request, only consumed while IDLE.
    always_comb begin
        w_valid    = 1'b1;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = c_SZ_WORD;
        case (opcode)
            6'b100000: begin w_size = c_SZ_BYTE; w_signed = 1'b1; end
            6'b100001: begin w_size = c_SZ_HALF; w_signed = 1'b1; end
            6'b100011: w_size = c_SZ_WORD;
            6'b100100: w_size = c_SZ_BYTE;
            6'b100101: w_size = c_SZ_HALF;
            6'b101000: begin w_size = c_SZ_BYTE; w_is_store = 1'b1; end
            6'b101001: begin w_size = c_SZ_HALF; w_is_store = 1'b1; end
            6'b101011: begin w_size = c_SZ_WORD; w_is_store = 1'b1; end
            default:   w_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata      = store_data;
        case (w_size)
            c_SZ_BYTE: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            c_SZ_HALF: begin
                w_misaligned = addr[0];
                w_be         = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{store_data[15:0]}};
            end
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    // Lane extraction works on the live read word at the completing edge.
    assign w_byte = dp_readdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? dp_readdata[31:16] : dp_readdata[15:0];

    always_comb begin
        case (r_size)
            c_SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default:   w_load = dp_readdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_signed    <= 1'b0;
            r_size      <= c_SZ_BYTE;
            r_off       <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            load_result <= 32'd0;
            dp_address  <= 32'd0;
            writedata   <= 32'd0;
            byteenable  <= 4'd0;
            read_dp     <= 1'b0;
            write_dp    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_unused_ok | !w_unused_ok) begin
                        busy <= 1'b1;
                        if (!w_valid || w_misaligned) begin
                            r_state     <= S_ERR;
                            done        <= 1'b1;
                            fault       <= 1'b1;
                            load_result <= 32'd0;
                        end else begin
                            r_state    <= S_REQ;
                            r_is_store <= w_is_store;
                            r_signed   <= w_signed;
                            r_size     <= w_size;
                            r_off      <= addr[1:0];
                            dp_address <= {addr[31:2], 2'b00};
                            writedata  <= w_wdata;
                            byteenable <= w_be;
                            read_dp    <= !w_is_store;
                            write_dp   <= w_is_store;
                        end
                    end
                end
                S_REQ: begin
                    if (!stall) begin
                        r_state     <= S_RESP;
                        read_dp     <= 1'b0;
                        write_dp    <= 1'b0;
                        done        <= 1'b1;
                        load_result <= r_is_store ? 32'd0 : w_load;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    fault   <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_data_port_master.sv
// ============================================================================
// Module      : tb_mips_data_port_master
// Description : Directed plus random load/store checks against a lane-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_data_port_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] load_result;
    logic [31:0] dp_address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        read_dp;
    logic        write_dp;
    logic [31:0] dp_readdata;
    logic        stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_data_port_master #(.RESET_PC_UNUSED(0)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr),
        .store_data(store_data), .busy(busy), .done(done), .fault(fault),
        .load_result(load_result), .dp_address(dp_address), .writedata(writedata),
        .byteenable(byteenable), .read_dp(read_dp), .write_dp(write_dp),
        .dp_readdata(dp_readdata), .stall(stall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: access width in bytes, direction and signedness per opcode.
    function automatic void decode(input logic [5:0] op, output bit ok, output bit st,
                                   output int nb, output bit sg);
        ok = 1; st = 0; nb = 4; sg = 0;
        case (op)
            6'b100000: begin nb = 1; sg = 1; end
            6'b100001: begin nb = 2; sg = 1; end
            6'b100011: nb = 4;
            6'b100100: nb = 1;
            6'b100101: nb = 2;
            6'b101000: begin nb = 1; st = 1; end
            6'b101001: begin nb = 2; st = 1; end
            6'b101011: begin nb = 4; st = 1; end
            default:   ok = 0;
        endcase
    endfunction

    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int ns);
        bit ok, st, sg, err;
        int nb, first;
        logic [31:0] e_be, e_wd, e_ld;
        decode(op, ok, st, nb, sg);
        first = int'(a[1:0]);
        err = !ok || (first % nb != 0);
        e_be = 0;
        e_wd = 0;
        for (int k = 0; k < 4; k++) begin
            if (k >= first && k < first + nb) e_be[k] = 1'b1;
            e_wd[8*k +: 8] = sd[8*(k % nb) +: 8];
        end
        e_ld = rd >> (8 * first);
        if (nb < 4) e_ld = e_ld & ((32'd1 << (8 * nb)) - 32'd1);
        if (sg && e_ld[8*nb-1]) e_ld = e_ld | ~((32'd1 << (8 * nb)) - 32'd1);
        if (st) e_ld = 0;

        start = 1; opcode = op; addr = a; store_data = sd;
        stall = (ns > 0);
        dp_readdata = (ns > 0) ? $urandom : rd;
        step();
        start = 0;
        if (err) begin
            check("err_done", done, 1);
            check("err_fault", fault, 1);
            check("err_busy", busy, 1);
            check("err_rd_wr", {read_dp, write_dp}, 0);
            check("err_result", load_result, 0);
            step();
            check("err_after_done", {done, fault, busy}, 0);
            check("err_after_rd_wr", {read_dp, write_dp}, 0);
            return;
        end
        for (int i = 0; i <= ns; i++) begin
            check("req_busy", busy, 1);
            check("req_done", done, 0);
            check("req_read", read_dp, !st);
            check("req_write", write_dp, st);
            check("req_addr", dp_address, {a[31:2], 2'b00});
            check("req_be", byteenable, e_be);
            if (st) check("req_wdata", writedata, e_wd);
            if (i == ns) break;
            start = 1'($urandom_range(0, 1));
            opcode = 6'b100011; addr = $urandom; store_data = $urandom;
            step();
            stall = (i + 1 < ns);
            dp_readdata = (i + 1 < ns) ? $urandom : rd;
        end
        start = 0;
        step();
        check("resp_done", done, 1);
        check("resp_fault", fault, 0);
        check("resp_busy", busy, 1);
        check("resp_rd_wr", {read_dp, write_dp}, 0);
        check("resp_result", load_result, e_ld);
        dp_readdata = $urandom;
        step();
        check("idle_done", {done, busy}, 0);
        check("idle_result_held", load_result, e_ld);
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                6'b100101, 6'b101000, 6'b101001, 6'b101011};
        rst = 1; start = 0; opcode = 0; addr = 0; store_data = 0; dp_readdata = 0; stall = 0;
        step();
        step();
        check("rst_ctrl", {busy, done, fault, read_dp, write_dp}, 0);
        check("rst_be", byteenable, 0);
        check("rst_addr", dp_address, 0);
        check("rst_wdata", writedata, 0);
        check("rst_result", load_result, 0);
        rst = 0;
        step();

        do_op(6'b100011, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        do_op(6'b100000, 32'h13,  32'h0,        32'h80FF1234, 0);
        check("lb_literal", load_result, 32'hFFFFFF80);
        do_op(6'b100100, 32'h13,  32'h0,        32'h80FF1234, 0);
        check("lbu_literal", load_result, 32'h00000080);
        do_op(6'b100101, 32'h12,  32'h0,        32'h80FF1234, 0);
        check("lhu_literal", load_result, 32'h000080FF);
        do_op(6'b101001, 32'h22,  32'hAAAA5678, 32'h12345678, 0);
        do_op(6'b101011, 32'h100, 32'hCAFEF00D, 32'h0,        3);
        do_op(6'b100011, 32'h102, 32'h0,        32'h11111111, 0);
        do_op(6'b101110, 32'h100, 32'h0,        32'h11111111, 0);

        // Reset while a load is stalled in the request phase.
        start = 1; opcode = 6'b100011; addr = 32'h40; stall = 1;
        step();
        start = 0;
        step();
        check("mid_req_read", read_dp, 1);
        rst = 1;
        step();
        rst = 0; stall = 0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_read", read_dp, 0);
        check("rst_mid_be", byteenable, 0);
        check("rst_mid_done", done, 0);
        step();
        check("rst_mid_no_done", {done, busy}, 0);
        do_op(6'b100011, 32'h44, 32'h0, 32'h0BADF00D, 0);

        for (int n = 0; n < 80; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            do_op(op, $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mips_data_port_master.md
Name: mips_data_port_master

Overview:
- CPU-side load/store initiator for the data port of the Harvard memory (`dp_*`, `writedata`, `byteenable`, `read_dp`, `write_dp`, `stall`).
- Takes one MIPS load/store request at a time from the execute stage, identified by its 6-bit opcode.
- Drives a word-aligned memory transaction, honours `stall`, and returns the sign- or zero-extended load result with a one-cycle `done` pulse.
- Byte lanes are little-endian: lane k is bits 8k+7:8k and holds the byte at address offset k.

Parameters:
- RESET_PC_UNUSED, 0: reserved, no effect; keeps the parameter list non-empty for wrapper tooling.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request strobe; sampled only in IDLE
- opcode  in  6  MIPS opcode: 100000 LB, 100001 LH, 100011 LW, 100100 LBU, 100101 LHU, 101000 SB, 101001 SH, 101011 SW
- addr  in  32  byte address of the access
- store_data  in  32  store source register; low byte/half used for SB/SH
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; misaligned address or unsupported opcode
- load_result  out  32  extended load value, valid with done
- dp_address  out  32  {addr[31:2],2'b00}
- writedata  out  32  lane-replicated store data
- byteenable  out  4  active lanes
- read_dp  out  1  data-port read request
- write_dp  out  1  data-port write request
- dp_readdata  in  32  memory read word, valid in the completing cycle
- stall  in  1  memory not ready; request must be held

Behaviour:
- Reset (synchronous, active-high, any state, including mid-transaction):
  - Next state IDLE; `busy`, `done`, `fault`, `read_dp`, `write_dp` = 0.
  - `byteenable`, `dp_address`, `writedata`, `load_result` = 0.
  - An in-flight request is dropped; no `done` is issued for it.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE:
  - On `start`=1, latch `opcode`, `addr`, `store_data`.
  - Misalignment is `addr[0]`=1 for halfword ops, or `addr[1:0]`≠0 for word ops. Misaligned or unsupported opcode → ERR; otherwise → REQ.
- REQ:
  - Drive `read_dp` (loads) or `write_dp` (stores), never both.
  - Hold `dp_address`, `writedata` and `byteenable` stable from latched values.
  - A transaction completes at the rising edge where the request is high and `stall`=0. On that edge, capture `dp_readdata` and go to RESP.
  - While `stall`=1, remain in REQ with all outputs unchanged.
- RESP:
  - `done`=1 and `fault`=0 for exactly one cycle; `read_dp`/`write_dp` = 0.
  - `load_result` is valid (0 for stores). Next state IDLE.
- ERR:
  - `done`=1 and `fault`=1 for one cycle; no memory request is issued.
  - `load_result`=0. Next state IDLE.
- Start handling: `start` is ignored outside IDLE. A `start` in the cycle after `done` is accepted, because the FSM is back in IDLE.
- Byte enables: b = `addr[1:0]`.
  - LB/LBU/SB: 1<<b.
  - LH/LHU/SH: 0011 if `addr[1]`=0, else 1100.
  - LW/SW: 1111.
  - Loads still drive the enables; the memory may ignore them.
- Store data:
  - SB: `store_data[7:0]` replicated to all 4 lanes.
  - SH: `store_data[15:0]` replicated to both halves.
  - SW: unchanged.
- Load extraction:
  - Byte = lane b of the captured word. Half = bits 15:0 if `addr[1]`=0, else bits 31:16.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- `load_result` holds its value until the next `done`.
- Latency:
  - `start` edge → REQ for 1 cycle → `done` visible 2 cycles after `start` with zero stall.
  - Each stall cycle adds 1 cycle.
  - An error completes with `done` 1 cycle after `start`.

Test Plan:
- LW at 0x00000010, `dp_readdata`=0xDEADBEEF, no stall → `read_dp`=1 for 1 cycle, `dp_address`=0x10, `byteenable`=1111; `done` 2 cycles after `start`, `load_result`=0xDEADBEEF, `fault`=0.
- LB at 0x00000013 with word 0x80FF1234 → `byteenable`=1000, `load_result`=0xFFFFFF80. Same address with LBU → 0x00000080. LHU at 0x12 → 0x000080FF.
- SH at 0x00000022, `store_data`=0xAAAA5678 → `write_dp`=1, `dp_address`=0x20, `writedata`=0x56785678, `byteenable`=1100; `done`=1, `load_result`=0.
- SW at 0x100 with `stall` held high for 3 cycles → `write_dp`, `writedata` and `dp_address` stable throughout; `done` at cycle 5 after `start`; `start` pulses during REQ are ignored.
- LW at 0x102 → no `read_dp`/`write_dp` ever; `done`=`fault`=1 one cycle after `start`. Opcode 101110 (SWR, unsupported) → same response.
- `rst` asserted mid-REQ during stall → next cycle IDLE, `read_dp`=0, `byteenable`=0, no `done`; a following LW completes normally.
